// File: rtl/pb_mux_pkg.sv
// Shared constants and helpers for the PicoBlaze input-port multiplexer.
// Default port addresses for the flag word, the overrun word and channel 0.
package pb_mux_pkg;

  localparam logic [7:0] PB_FLAG_ID = 8'h00;
  localparam logic [7:0] PB_OVR_ID  = 8'h01;
  localparam logic [7:0] PB_CH_BASE = 8'h10;

  // Widening to int keeps the upper bound from wrapping at 8 bits.
  function automatic logic ch_hit(input logic [7:0] port_id, input logic [7:0] base, input int n);
    return (int'(port_id) >= int'(base)) && (int'(port_id) < (int'(base) + n));
  endfunction

endpackage

// File: rtl/sticky_flag_bank.sv
// Event flag and overrun registers; PB_MUX_STICKY_EN selects sticky clear-on-read
// behaviour, otherwise flags are a one-cycle registered copy of flag_set.
module sticky_flag_bank #(
  parameter int N_FLAG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_FLAG-1:0] flag_set,
  input  logic              clr_flag,
  input  logic              clr_ovr,
  output logic [N_FLAG-1:0] flag_q,
  output logic [N_FLAG-1:0] ovr_q
);

`ifdef PB_MUX_STICKY_EN
  logic [N_FLAG-1:0] r_flag;
  logic [N_FLAG-1:0] r_ovr;
  logic [N_FLAG-1:0] w_ovr_set;

  // A new event while the flag is still pending counts as overrun, unless the poll clears it now.
  assign w_ovr_set = flag_set & r_flag & ~{N_FLAG{clr_flag}};

  // Set wins over clear so an event coinciding with the read is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag <= '0;
      r_ovr  <= '0;
    end else begin
      r_flag <= flag_set  | (r_flag & ~{N_FLAG{clr_flag}});
      r_ovr  <= w_ovr_set | (r_ovr  & ~{N_FLAG{clr_ovr}});
    end
  end

  assign flag_q = r_flag;
  assign ovr_q  = r_ovr;
`else
  logic [N_FLAG-1:0] r_flag;
  logic              w_unused_clr;

  assign w_unused_clr = clr_flag ^ clr_ovr;

  // Legacy pass-through: flag mirrors the event pulse one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag <= '0;
    end else begin
      r_flag <= flag_set;
    end
  end

  assign flag_q = r_flag;
  assign ovr_q  = '0;
`endif

endmodule

// File: rtl/pb_in_port_mux.sv
// Registered PicoBlaze input-port multiplexer: channels, flag word and overrun word.
// Optional sticky clear-on-read flags are enabled with the PB_MUX_STICKY_EN macro.
module pb_in_port_mux
  import pb_mux_pkg::*;
#(
  parameter int         DATA_W  = 8,
  parameter int         N_CH    = 6,
  parameter int         N_FLAG  = 3,
  parameter logic [7:0] CH_BASE = PB_CH_BASE,
  parameter logic [7:0] FLAG_ID = PB_FLAG_ID,
  parameter logic [7:0] OVR_ID  = PB_OVR_ID
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               port_id,
  input  logic                     read_strobe,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [N_FLAG-1:0]        flag_set,
  output logic [DATA_W-1:0]        in_port,
  output logic [N_FLAG-1:0]        flag_q,
  output logic [N_FLAG-1:0]        ovr_q
);

  localparam bit ADDR_OVERLAP = (FLAG_ID == OVR_ID) ||
                                ch_hit(FLAG_ID, CH_BASE, N_CH) ||
                                ch_hit(OVR_ID, CH_BASE, N_CH);

  generate
    if (ADDR_OVERLAP) begin : g_addr_overlap
      $error("pb_in_port_mux: FLAG_ID, OVR_ID and channel range overlap");
    end
  endgenerate

  logic              w_clr_flag;
  logic              w_clr_ovr;
  logic [7:0]        w_ch_idx;
  logic [DATA_W-1:0] w_dec;
  logic [DATA_W-1:0] r_in_port;

  assign w_clr_flag = read_strobe && (port_id == FLAG_ID);
  assign w_clr_ovr  = read_strobe && (port_id == OVR_ID);
  assign w_ch_idx   = port_id - CH_BASE;

  sticky_flag_bank #(
    .N_FLAG (N_FLAG)
  ) u_flags (
    .clk      (clk),
    .rst      (rst),
    .flag_set (flag_set),
    .clr_flag (w_clr_flag),
    .clr_ovr  (w_clr_ovr),
    .flag_q   (flag_q),
    .ovr_q    (ovr_q)
  );

  // Address decode; status words are zero-extended, unmapped addresses read as zero.
  always_comb begin
    w_dec = '0;
    if (port_id == FLAG_ID) begin
      w_dec[N_FLAG-1:0] = flag_q;
    end else if (port_id == OVR_ID) begin
      w_dec[N_FLAG-1:0] = ovr_q;
    end else if (ch_hit(port_id, CH_BASE, N_CH)) begin
      for (int k = 0; k < N_CH; k++) begin
        w_dec = (w_ch_idx == 8'(k)) ? ch_data[k*DATA_W +: DATA_W] : w_dec;
      end
    end else begin
      w_dec = '0;
    end
  end

  // Read data is captured every cycle so it is valid on the edge after the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_port <= '0;
    end else begin
      r_in_port <= w_dec;
    end
  end

  assign in_port = r_in_port;

endmodule
